pacman_pixel_renderer: RTL
==========================

# pacman_pixel_renderer

Pixel pipeline directly downstream of the VGA timing generator in the PAC-MAN design. It consumes the raw pixel position, video_on and sync strobes and resolves each pixel against a 40x30 maze tile RAM (16x16-pixel tiles) and a Pac-Man sprite. It drives 12-bit RGB plus sync outputs that are delay-matched to the pixel pipeline. It also provides the game logic with a tile write port and a once-per-frame tick.

## Interface
- TILE_ROWS, 30, maze rows of 16 px.
- TILE_COLS, 40, maze columns of 16 px.
- NUM_TILES, 1200, TILE_ROWS*TILE_COLS; RAM depth.
- clk  in  1  pixel clock (~25 MHz); same clock as the timing generator.
- rst  in  1  asynchronous, active-high reset.
- video_on  in  1  visible-area flag from the timing generator.
- pixel_x  in  10  column, 0..639; 0 during blanking.
- pixel_y  in  10  row, 0..479; 0 during blanking.
- h_sync_in  in  1  active-low hsync from the timing generator.
- v_sync_in  in  1  active-low vsync from the timing generator.
- wr_en  in  1  tile write strobe from game logic.
- wr_addr  in  11  tile index, row*40+col.
- wr_data  in  2  tile code: 0 empty, 1 wall, 2 dot, 3 power pellet.
- pac_x  in  10  sprite top-left column.
- pac_y  in  10  sprite top-left row.
- rgb  out  12  {R[3:0],G[3:0],B[3:0]} to the DAC pins.
- h_sync  out  1  hsync delayed by 3 cycles.
- v_sync  out  1  vsync delayed by 3 cycles.
- frame_tick  out  1  one-cycle pulse per frame.

## Operation
- Tile RAM: NUM_TILES x 2 bits, one write port and one synchronous read port. Not cleared by rst; contents survive reset.
- Writes: a write with wr_en=1 and wr_addr<1200 commits at the clock edge. wr_addr>=1200 is ignored.
- Read-during-write to the same address returns the old data; the new value is visible from the next read.
- Stage 1 (registered), input pixel:
  - tile address = pixel_y[9:4]*40 + pixel_x[9:4], computed as (y<<5)+(y<<3)+x in 11 bits.
  - Register offsets ox=pixel_x[3:0] and oy=pixel_y[3:0].
  - Sprite hit: compare in 11-bit unsigned so there is no wrap at 1023. Hit when pixel_x in [pac_x_l, pac_x_l+15] and pixel_y in [pac_y_l, pac_y_l+15], AND (2dx-15)^2+(2dy-15)^2 <= 225, where dx,dy are 0..15 offsets into the sprite. Squares are 8 bits; the sum is 9 bits.
  - Register video_on and both syncs.
- Stage 2: RAM read data is valid. Offsets, sprite hit, video_on and syncs are carried forward one register.
- Stage 3, colour priority:
  - video_on low: rgb=12'h000.
  - Otherwise, sprite hit: 12'hFF0.
  - Otherwise, tile 1 (wall): 12'h00F.
  - Otherwise, tile 2 (dot): 12'hFCA when ox and oy are both in 6..9.
  - Otherwise, tile 3 (power pellet): 12'hFCA when ox and oy are both in 4..11 and frame_cnt[4]==0.
  - Otherwise: 12'h000.
- Frame tick: a registered copy of v_sync_in is kept. frame_tick=1 for one cycle on the cycle after a falling edge of v_sync_in is detected.
- On frame_tick:
  - pac_x_l<=pac_x and pac_y_l<=pac_y. The latched position is used for the whole next frame, so there is no tearing.
  - frame_cnt (6 bits) increments, wrapping 63->0.

## Timing
- Latency: rgb, h_sync and v_sync for a given input pixel appear exactly 3 clocks after that pixel's inputs. The sync/colour relationship from the timing generator is preserved.
- Reset values: rgb=0, h_sync=1, v_sync=1, frame_tick=0, frame_cnt=0, pac_x_l=0, pac_y_l=0. All pipeline valid/sync registers are cleared to the inactive state (video_on 0, syncs 1).
- Reset mid-frame: outputs go to reset values asynchronously. After release, outputs track the inputs 3 cycles later. No false frame_tick is generated, because the registered v_sync resets to 1.
- Write and display of the same tile in the same cycle: the display shows the old code for that pixel.
- frame_tick may coincide with a write; the two are independent.
- A sprite partly off-screen (pac_x>624) renders only its visible columns; no wrap to the left edge.

## Test plan
- Reset: assert rst with inputs toggling -> rgb=000, h_sync=v_sync=1, frame_tick=0. Release -> h_sync follows h_sync_in with exactly 3-cycle delay.
- Wall: write tile 0 = 1. Drive pixel (0,0) with video_on=1 -> rgb=00F three cycles later. Pixel (16,0) -> 000. Same pixel with video_on=0 -> 000.
- Dot: write addr 41 = 2 (row 1, col 1).
  - Pixel (22,23) -> FCA.
  - Pixel (16,16) -> 000.
  - Write addr 1200 = 1 -> RAM unchanged, pixel (0,0) -> 000 on a fresh RAM.
- Sprite: pac_x=pac_y=100, then a v_sync falling edge.
  - Pixel (107,107) -> FF0.
  - Pixel (100,107) -> underlying tile colour, since the column-0 distance sum is 226.
  - Change pac_x to 200 mid-frame -> (107,107) is still FF0 until the next frame_tick.
- Pellet blink: tile 0 = 3, pixel (8,8). Over 32 v_sync falls -> FCA while frame_cnt is 0..15, 000 while 16..31. frame_tick fires once per v_sync fall.
- Read-during-write: write addr 0 = 1 in the same cycle stage 1 presents (0,0) with old code 0 -> rgb=000 for that pixel; the next (0,0) -> 00F.

Source files
------------

// File: rtl/pacman_pixel_renderer.sv
// Pixel pipeline that follows the VGA timing generator. Each pixel is resolved
// against the maze tile RAM and the Pac-Man sprite. RGB and syncs come out
// three clocks after the pixel's inputs.
//
// Ports:
//   clk, rst               pixel clock, async active-high reset
//   video_on, pixel_x/y    visible flag and pixel position from the timing generator
//   h_sync_in, v_sync_in   active-low syncs from the timing generator
//   wr_en/wr_addr/wr_data  tile write port for game logic (addr = row*40+col)
//   pac_x, pac_y           sprite top-left; sampled once per frame on frame_tick
//   rgb                    {R,G,B} 4 bits each
//   h_sync, v_sync         syncs delayed to line up with rgb
//   frame_tick             one-cycle pulse after each vsync falling edge
module pacman_pixel_renderer #(
   parameter int unsigned TILE_ROWS = 30,
   parameter int unsigned TILE_COLS = 40,
   parameter int unsigned NUM_TILES = TILE_ROWS * TILE_COLS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        video_on,
   input  logic [9:0]  pixel_x,
   input  logic [9:0]  pixel_y,
   input  logic        h_sync_in,
   input  logic        v_sync_in,
   input  logic        wr_en,
   input  logic [10:0] wr_addr,
   input  logic [1:0]  wr_data,
   input  logic [9:0]  pac_x,
   input  logic [9:0]  pac_y,
   output logic [11:0] rgb,
   output logic        h_sync,
   output logic        v_sync,
   output logic        frame_tick
);

   localparam logic [11:0] ColBlack  = 12'h000;
   localparam logic [11:0] ColWall   = 12'h00F;
   localparam logic [11:0] ColFood   = 12'hFCA;
   localparam logic [11:0] ColSprite = 12'hFF0;

   // Tile RAM, deliberately outside reset so the maze survives rst.
   logic [1:0]  tile_ram [NUM_TILES];
   logic [1:0]  tile_q;

   // Stage 1
   logic [10:0] addr_q;
   logic [3:0]  ox1_q, oy1_q;
   logic        hit1_q, vid1_q, hs1_q, vs1_q;
   // Stage 2
   logic [3:0]  ox2_q, oy2_q;
   logic        hit2_q, vid2_q, hs2_q, vs2_q;

   logic        vs_in_q;
   logic [9:0]  pac_x_q, pac_y_q;
   logic [5:0]  frame_cnt_q;

   logic [10:0] tile_addr;
   logic        sprite_hit;
   logic [11:0] colour;

   // 40*y + x as (y<<5)+(y<<3)+x.
   always_comb begin
      tile_addr = ({5'd0, pixel_y[9:4]} << 5) + ({5'd0, pixel_y[9:4]} << 3)
                + {5'd0, pixel_x[9:4]};
   end

   // Bounding box compared at 11 bits so a sprite near x=1023 never wraps.
   // The disc test uses |2d-15|, which is always odd: {d[2:0],1} or its
   // complement depending on which half of the sprite d falls in.
   always_comb begin
      logic [10:0] px, py, bx, by;
      logic [3:0]  dx, dy, mx, my;
      logic [7:0]  sqx, sqy;
      logic [8:0]  sum;
      px  = {1'b0, pixel_x};
      py  = {1'b0, pixel_y};
      bx  = {1'b0, pac_x_q};
      by  = {1'b0, pac_y_q};
      dx  = pixel_x[3:0] - pac_x_q[3:0];
      dy  = pixel_y[3:0] - pac_y_q[3:0];
      mx  = {dx[3] ? dx[2:0] : ~dx[2:0], 1'b1};
      my  = {dy[3] ? dy[2:0] : ~dy[2:0], 1'b1};
      sqx = {4'd0, mx} * {4'd0, mx};
      sqy = {4'd0, my} * {4'd0, my};
      sum = {1'b0, sqx} + {1'b0, sqy};
      sprite_hit = (px >= bx) && (px <= bx + 11'd15) &&
                   (py >= by) && (py <= by + 11'd15) && (sum <= 9'd225);
   end

   // Read returns the old word when the same address is written this edge.
   always_ff @(posedge clk) begin
      if (wr_en && (wr_addr < 11'(NUM_TILES))) begin
         tile_ram[wr_addr] <= wr_data;
      end
      tile_q <= tile_ram[addr_q];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q <= '0;
         ox1_q  <= '0;
         oy1_q  <= '0;
         hit1_q <= 1'b0;
         vid1_q <= 1'b0;
         hs1_q  <= 1'b1;
         vs1_q  <= 1'b1;
         ox2_q  <= '0;
         oy2_q  <= '0;
         hit2_q <= 1'b0;
         vid2_q <= 1'b0;
         hs2_q  <= 1'b1;
         vs2_q  <= 1'b1;
      end else begin
         addr_q <= tile_addr;
         ox1_q  <= pixel_x[3:0];
         oy1_q  <= pixel_y[3:0];
         hit1_q <= sprite_hit;
         vid1_q <= video_on;
         hs1_q  <= h_sync_in;
         vs1_q  <= v_sync_in;
         ox2_q  <= ox1_q;
         oy2_q  <= oy1_q;
         hit2_q <= hit1_q;
         vid2_q <= vid1_q;
         hs2_q  <= hs1_q;
         vs2_q  <= vs1_q;
      end
   end

   always_comb begin
      colour = ColBlack;
      if (!vid2_q) begin
         colour = ColBlack;
      end else if (hit2_q) begin
         colour = ColSprite;
      end else begin
         unique case (tile_q)
            2'd1: colour = ColWall;
            2'd2: begin
               if (ox2_q >= 4'd6 && ox2_q <= 4'd9 && oy2_q >= 4'd6 && oy2_q <= 4'd9) begin
                  colour = ColFood;
               end
            end
            2'd3: begin
               if (ox2_q >= 4'd4 && ox2_q <= 4'd11 && oy2_q >= 4'd4 && oy2_q <= 4'd11 &&
                   !frame_cnt_q[4]) begin
                  colour = ColFood;
               end
            end
            default: colour = ColBlack;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rgb    <= ColBlack;
         h_sync <= 1'b1;
         v_sync <= 1'b1;
      end else begin
         rgb    <= colour;
         h_sync <= hs2_q;
         v_sync <= vs2_q;
      end
   end

   // vs_in_q resets high so releasing reset with vsync low is not an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vs_in_q     <= 1'b1;
         frame_tick  <= 1'b0;
         pac_x_q     <= '0;
         pac_y_q     <= '0;
         frame_cnt_q <= '0;
      end else begin
         vs_in_q    <= v_sync_in;
         frame_tick <= vs_in_q & ~v_sync_in;
         if (frame_tick) begin
            pac_x_q     <= pac_x;
            pac_y_q     <= pac_y;
            frame_cnt_q <= frame_cnt_q + 6'd1;
         end
      end
   end

endmodule
